// File: rtl/ctrl_rgb_fade.sv
// Fades the RGB LED peripheral toward software-programmed target colours,
// one step per channel per tick, by mastering Wishbone writes to its duty registers.
module ctrl_rgb_fade #(
    parameter int DIV_W = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wb_we_i,
    input  logic [3:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_stb_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       m_wb_we_o,
    output logic [3:0] m_wb_adr_o,
    output logic [7:0] m_wb_dat_o,
    output logic       m_wb_stb_o,
    input  logic       m_wb_ack_i,
    output logic       busy_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t            state_r, state_nx_s;
    logic [2:0][7:0]   tgt_r;
    logic [2:0][7:0]   cur_r, cur_nx_s;
    logic [15:0]       period_r;
    logic              en_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [DIV_W-1:0]  per_s, limit_s;
    logic              tick_s, wr_s, sync_s, busy_s;
    logic [2:0]        pend_r, pend_nx_s, step_mask_s, rem_s;
    logic              m_stb_r, m_stb_nx_s, m_we_r, m_we_nx_s;
    logic [3:0]        m_adr_r, m_adr_nx_s;
    logic [7:0]        m_dat_r, m_dat_nx_s;
    logic [7:0]        rd_s;

    function automatic logic [1:0] first_ch(input logic [2:0] mask);
        if (mask[0]) begin
            first_ch = 2'd0;
        end else if (mask[1]) begin
            first_ch = 2'd1;
        end else begin
            first_ch = 2'd2;
        end
    endfunction

    function automatic logic [2:0] ch_bit(input logic [1:0] ch);
        ch_bit = 3'b001 << ch;
    endfunction

    assign wr_s    = wb_stb_i & wb_we_i;
    assign sync_s  = wr_s & (wb_adr_i == 4'h5) & wb_dat_i[1];
    // Periods of 0 and 1 both mean a tick on every enabled cycle.
    assign per_s   = period_r[DIV_W-1:0];
    assign limit_s = (per_s == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : per_s - DIV_W'(1);
    assign tick_s  = en_r & (cnt_r >= limit_s);
    assign busy_s  = (state_r == ST_SEND) | (cur_r != tgt_r);

    // Software-visible configuration registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tgt_r    <= '0;
            period_r <= 16'h0000;
            en_r     <= 1'b0;
        end else if (wr_s) begin
            case (wb_adr_i)
                4'h0:    tgt_r[0]       <= wb_dat_i;
                4'h1:    tgt_r[1]       <= wb_dat_i;
                4'h2:    tgt_r[2]       <= wb_dat_i;
                4'h3:    period_r[7:0]  <= wb_dat_i;
                4'h4:    period_r[15:8] <= wb_dat_i;
                4'h5:    en_r           <= wb_dat_i[0];
                default: ;
            endcase
        end
    end

    // Step divider; free-runs regardless of FSM state so dropped ticks keep cadence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (!en_r || tick_s) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

    // Next-state, colour stepping and master-cycle loading.
    always_comb begin
        state_nx_s  = state_r;
        pend_nx_s   = pend_r;
        cur_nx_s    = cur_r;
        m_stb_nx_s  = m_stb_r;
        m_we_nx_s   = m_we_r;
        m_adr_nx_s  = m_adr_r;
        m_dat_nx_s  = m_dat_r;
        step_mask_s = 3'b000;
        rem_s       = 3'b000;
        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    pend_nx_s  = 3'b111;
                    state_nx_s = ST_SEND;
                    m_stb_nx_s = 1'b1;
                    m_we_nx_s  = 1'b1;
                    m_adr_nx_s = 4'h0;
                    m_dat_nx_s = cur_r[0];
                end else if (tick_s) begin
                    for (int i = 0; i < 3; i++) begin
                        if (cur_r[i] < tgt_r[i]) begin
                            cur_nx_s[i]    = cur_r[i] + 8'd1;
                            step_mask_s[i] = 1'b1;
                        end else if (cur_r[i] > tgt_r[i]) begin
                            cur_nx_s[i]    = cur_r[i] - 8'd1;
                            step_mask_s[i] = 1'b1;
                        end else begin
                            cur_nx_s[i]    = cur_r[i];
                        end
                    end
                    if (step_mask_s != 3'b000) begin
                        pend_nx_s  = step_mask_s;
                        state_nx_s = ST_SEND;
                        m_stb_nx_s = 1'b1;
                        m_we_nx_s  = 1'b1;
                        m_adr_nx_s = {2'b00, first_ch(step_mask_s)};
                        m_dat_nx_s = cur_nx_s[first_ch(step_mask_s)];
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (m_wb_ack_i) begin
                    rem_s     = pend_r & ~ch_bit(m_adr_r[1:0]);
                    pend_nx_s = rem_s;
                    if (rem_s != 3'b000) begin
                        m_adr_nx_s = {2'b00, first_ch(rem_s)};
                        m_dat_nx_s = cur_r[first_ch(rem_s)];
                    end else begin
                        state_nx_s = ST_IDLE;
                        m_stb_nx_s = 1'b0;
                        m_we_nx_s  = 1'b0;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                pend_nx_s  = 3'b000;
                m_stb_nx_s = 1'b0;
                m_we_nx_s  = 1'b0;
            end
        endcase
    end

    // FSM state, colour and master-port registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            pend_r  <= 3'b000;
            cur_r   <= '0;
            m_stb_r <= 1'b0;
            m_we_r  <= 1'b0;
            m_adr_r <= 4'h0;
            m_dat_r <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            pend_r  <= pend_nx_s;
            cur_r   <= cur_nx_s;
            m_stb_r <= m_stb_nx_s;
            m_we_r  <= m_we_nx_s;
            m_adr_r <= m_adr_nx_s;
            m_dat_r <= m_dat_nx_s;
        end
    end

    // Config read mux; unmapped addresses read zero.
    always_comb begin
        rd_s = 8'h00;
        case (wb_adr_i)
            4'h0:    rd_s = tgt_r[0];
            4'h1:    rd_s = tgt_r[1];
            4'h2:    rd_s = tgt_r[2];
            4'h3:    rd_s = period_r[7:0];
            4'h4:    rd_s = period_r[15:8];
            4'h5:    rd_s = {7'b0000000, en_r};
            4'h6:    rd_s = {4'b0000, pend_r, busy_s};
            4'h8:    rd_s = cur_r[0];
            4'h9:    rd_s = cur_r[1];
            4'hA:    rd_s = cur_r[2];
            default: rd_s = 8'h00;
        endcase
    end

    assign wb_dat_o   = rd_s;
    assign wb_ack_o   = wb_stb_i;
    assign m_wb_stb_o = m_stb_r;
    assign m_wb_we_o  = m_we_r;
    assign m_wb_adr_o = m_adr_r;
    assign m_wb_dat_o = m_dat_r;
    assign busy_o     = busy_s;

endmodule
